// File: rtl/fmadd_mul_iterative_if.sv
// Operand/result handshake bundle between the FMADD operand stage, the iterative multiplier
// and the multiply post-normalization stage; master drives operands and out_ready.
interface fmadd_mul_iterative_if #(
   parameter int std_w = 31,
   parameter int man   = 22,
   parameter int exp   = 7,
   parameter int lzd   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [std_w:0]     in_A;
   logic [std_w:0]     in_B;
   logic [2:0]         in_rm;
   logic               out_valid;
   logic               out_ready;
   logic               out_sign;
   logic [exp+1:0]     out_exp_DB;
   logic [2*man+3:0]   out_multiplied_man;
   logic [lzd:0]       out_lzd;
   logic [2:0]         out_rm;
   logic               out_A_neg, out_A_pos, out_A_sub;
   logic               out_B_neg, out_B_pos, out_B_sub;

   modport master (
      output in_valid, in_A, in_B, in_rm, out_ready,
      input  in_ready, out_valid, out_sign, out_exp_DB, out_multiplied_man, out_lzd, out_rm,
      input  out_A_neg, out_A_pos, out_A_sub, out_B_neg, out_B_pos, out_B_sub
   );

   modport slave (
      input  in_valid, in_A, in_B, in_rm, out_ready,
      output in_ready, out_valid, out_sign, out_exp_DB, out_multiplied_man, out_lzd, out_rm,
      output out_A_neg, out_A_pos, out_A_sub, out_B_neg, out_B_pos, out_B_sub
   );
endinterface

// File: rtl/fmadd_mul_iterative.sv
// Iterative shift-add mantissa multiplier with operand classification; result valid man+4 cycles after accept,
// held until out_ready, no input accepted while busy. FMADD_MUL_RADIX4_EN retires two multiplier bits per cycle.
module fmadd_mul_iterative #(
   parameter int std_w = 31,
   parameter int man   = 22,
   parameter int exp   = 7,
   parameter int bias  = 127,
   parameter int lzd   = 4
) (
   input  logic clk,
   input  logic rst,
   fmadd_mul_iterative_if.slave bus
);
   localparam int sw = man + 2;
   localparam int pw = 2 * man + 4;
   localparam int cw = $clog2(sw + 1);
   localparam int zw = $clog2(pw + 1);
`ifdef FMADD_MUL_RADIX4_EN
   localparam int step = 2;
`else
   localparam int step = 1;
`endif
   localparam logic [exp:0] bias_v = (exp + 1)'(bias);
   localparam logic [exp:0] one_v  = (exp + 1)'(1);
   localparam logic [lzd:0] lz_max = '1;

   typedef enum logic [1:0] {IDLE, BUSY, LZC, DONE} state_t;
   state_t state;

   logic [exp:0]   ea, eb;
   logic           sub_a, sub_b, pos_a, pos_b;
   logic [sw-1:0]  sig_a, sig_b;
   logic [exp+1:0] exp_sum;
   logic [pw-1:0]  acc, mcand, acc_next;
   logic [sw-1:0]  mplier;
   logic [cw-1:0]  cnt;

   logic           op_sign;
   logic [exp+1:0] op_exp;
   logic [5:0]     op_cls;
   logic [2:0]     op_rm;

   logic           rdy, res_valid, res_sign;
   logic [exp+1:0] res_exp;
   logic [pw-1:0]  res_man;
   logic [lzd:0]   res_lzd;
   logic [2:0]     res_rm;
   logic [5:0]     res_cls;

   assign ea      = bus.in_A[man+1 +: exp+1];
   assign eb      = bus.in_B[man+1 +: exp+1];
   assign sub_a   = (ea == '0);
   assign sub_b   = (eb == '0);
   assign pos_a   = (ea >= bias_v);
   assign pos_b   = (eb >= bias_v);
   assign sig_a   = {!sub_a, bus.in_A[man:0]};
   assign sig_b   = {!sub_b, bus.in_B[man:0]};
   assign exp_sum = {1'b0, sub_a ? one_v : ea} + {1'b0, sub_b ? one_v : eb};

`ifdef FMADD_MUL_RADIX4_EN
   assign acc_next = acc + (mplier[0] ? mcand : '0) + (mplier[1] ? {mcand[pw-2:0], 1'b0} : '0);
`else
   assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

   // Zeros above the leading one, clamped to what the lzd port can express.
   function automatic logic [lzd:0] lead_zeros(input logic [pw-1:0] v);
      logic [zw-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = pw - 1; i >= 0; i--) begin
         if (v[i]) found = 1'b1;
         else if (!found) n = n + zw'(1);
      end
      return (n > zw'(lz_max)) ? lz_max : n[lzd:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rdy       <= 1'b1;
         res_valid <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         op_sign   <= 1'b0;
         op_exp    <= '0;
         op_cls    <= '0;
         op_rm     <= '0;
         res_sign  <= 1'b0;
         res_exp   <= '0;
         res_man   <= '0;
         res_lzd   <= '0;
         res_rm    <= '0;
         res_cls   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_sign <= bus.in_A[std_w] ^ bus.in_B[std_w];
               op_exp  <= exp_sum;
               op_cls  <= {!sub_a && !pos_a, pos_a && !sub_a, sub_a,
                           !sub_b && !pos_b, pos_b && !sub_b, sub_b};
               op_rm   <= bus.in_rm;
               acc     <= '0;
               mcand   <= {{(pw - sw){1'b0}}, sig_a};
               mplier  <= sig_b;
               cnt     <= cw'(sw);
               rdy     <= 1'b0;
               state   <= BUSY;
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand << step;
               mplier <= mplier >> step;
               if (cnt <= cw'(step)) state <= LZC;
               else cnt <= cnt - cw'(step);
            end
            LZC: begin
               // Results are published all at once so nothing partial ever reaches the port.
               res_man   <= acc;
               res_lzd   <= lead_zeros(acc);
               res_sign  <= op_sign;
               res_exp   <= op_exp;
               res_cls   <= op_cls;
               res_rm    <= op_rm;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (bus.out_ready) begin
               res_valid <= 1'b0;
               rdy       <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready           = rdy;
   assign bus.out_valid          = res_valid;
   assign bus.out_sign           = res_sign;
   assign bus.out_exp_DB         = res_exp;
   assign bus.out_multiplied_man = res_man;
   assign bus.out_lzd            = res_lzd;
   assign bus.out_rm             = res_rm;
   assign {bus.out_A_neg, bus.out_A_pos, bus.out_A_sub,
           bus.out_B_neg, bus.out_B_pos, bus.out_B_sub} = res_cls;
endmodule

// File: tb/tb_fmadd_mul_iterative.sv
// Bench for fmadd_mul_iterative: directed vectors, randomized operands against an arithmetic model,
// backpressure, back-to-back acceptance and reset during an operation.
module tb_fmadd_mul_iterative;
`ifdef FMADD_MUL_RADIX4_EN
   localparam int LAT = 14;
`else
   localparam int LAT = 26;
`endif

   typedef struct packed {
      logic        sign;
      logic [8:0]  exp_db;
      logic [47:0] man;
      logic [4:0]  lzd;
      logic [2:0]  rm;
      logic        a_neg, a_pos, a_sub, b_neg, b_pos, b_sub;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   fmadd_mul_iterative_if bus();
   fmadd_mul_iterative dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic res_t sample();
      res_t r;
      r.sign   = bus.out_sign;
      r.exp_db = bus.out_exp_DB;
      r.man    = bus.out_multiplied_man;
      r.lzd    = bus.out_lzd;
      r.rm     = bus.out_rm;
      r.a_neg  = bus.out_A_neg;
      r.a_pos  = bus.out_A_pos;
      r.a_sub  = bus.out_A_sub;
      r.b_neg  = bus.out_B_neg;
      r.b_pos  = bus.out_B_pos;
      r.b_sub  = bus.out_B_sub;
      return r;
   endfunction

   // Reference: real integer product of the significands, bit length via log2.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
      res_t   r;
      int     ea, eb, lz;
      longint sa, sb, p;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sa = longint'(a[22:0]) + ((ea == 0) ? 0 : 8388608);
      sb = longint'(b[22:0]) + ((eb == 0) ? 0 : 8388608);
      p  = sa * sb;
      lz = 48 - $clog2(p + 1);
      if (lz > 31) lz = 31;
      r.sign   = a[31] ^ b[31];
      r.exp_db = 9'(((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb));
      r.man    = p[47:0];
      r.lzd    = 5'(lz);
      r.rm     = rm;
      r.a_sub  = (ea == 0);
      r.a_pos  = (ea >= 127);
      r.a_neg  = (ea != 0) && (ea < 127);
      r.b_sub  = (eb == 0);
      r.b_pos  = (eb >= 127);
      r.b_neg  = (eb != 0) && (eb < 127);
      return r;
   endfunction

   // Presents one operand pair, then waits (bounded) for out_valid; leaves out_valid pending.
   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                           output logic rdy_seen, output int lat, output res_t got);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_A     = a;
      bus.in_B     = b;
      bus.in_rm    = rm;
      rdy_seen     = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      got = sample();
   endtask

   task automatic test_reset();
      res_t got;
      repeat (3) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: outputs=%h valid=%b ready=%b, required 0/0/1", got, bus.out_valid, bus.in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] va[4] = '{32'h3FC00000, 32'hBF000000, 32'h00000001, 32'h00000000};
      logic [31:0] vb[4] = '{32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40490FDB};
      res_t ex, got;
      logic rdy_seen;
      int   lat;
      for (int i = 0; i < 4; i++) begin
         ex = '0;
         ex.rm = 3'(i + 1);
         case (i)
            0: begin ex.exp_db = 9'd254; ex.man = 48'h900000000000; ex.lzd = 5'd0;  ex.a_pos = 1'b1; ex.b_pos = 1'b1; end
            1: begin ex.sign = 1'b1; ex.exp_db = 9'd254; ex.man = 48'h400000000000; ex.lzd = 5'd1; ex.a_neg = 1'b1; ex.b_pos = 1'b1; end
            2: begin ex.exp_db = 9'd128; ex.man = 48'h000000800000; ex.lzd = 5'd24; ex.a_sub = 1'b1; ex.b_pos = 1'b1; end
            default: begin ex.exp_db = 9'd129; ex.man = 48'h0; ex.lzd = 5'd31; ex.a_sub = 1'b1; ex.b_pos = 1'b1; end
         endcase
         drive_op(va[i], vb[i], 3'(i + 1), rdy_seen, lat, got);
         vectors++;
         if (lat !== LAT || rdy_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL directed%0d latency: %0d ready=%b, required %0d ready=1", i, lat, rdy_seen, LAT);
         end
         vectors++;
         if (got !== ex) begin
            miscompares++;
            $display("FAIL directed%0d result: %h, required %h", i, got, ex);
         end
         bus.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.out_ready = 1'b0;
         vectors++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL directed%0d release: valid=%b ready=%b, required 0/1", i, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [2:0]  rm;
      res_t        ex, got;
      logic        rdy_seen;
      int          lat, d;
      for (int n = 0; n < 40; n++) begin
         a  = $urandom;
         b  = $urandom;
         rm = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a[30:23] = 8'h00;
         if ($urandom_range(0, 3) == 0) b[30:23] = 8'h00;
         if ($urandom_range(0, 5) == 0) a[22:0] = 23'h0;
         ex = model(a, b, rm);
         drive_op(a, b, rm, rdy_seen, lat, got);
         vectors++;
         if (lat !== LAT || got !== ex) begin
            miscompares++;
            $display("FAIL random%0d a=%h b=%h: lat=%0d res=%h, required lat=%0d res=%h", n, a, b, lat, got, LAT, ex);
         end
         d = $urandom_range(0, 3);
         repeat (d) @(negedge clk);
         bus.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.out_ready = 1'b0;
         vectors++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL random%0d release: valid=%b ready=%b, required 0/1", n, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      res_t ex, got;
      logic rdy_seen;
      int   lat;
      ex = model(32'h3FC00000, 32'hC0200000, 3'd5);
      drive_op(32'h3FC00000, 32'hC0200000, 3'd5, rdy_seen, lat, got);
      vectors++;
      if (got !== ex) begin
         miscompares++;
         $display("FAIL backpressure first result: %h, required %h", got, ex);
      end
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_A     = $urandom;
         bus.in_B     = $urandom;
         bus.in_rm    = 3'($urandom_range(0, 7));
         @(negedge clk);
         got = sample();
         vectors++;
         if (got !== ex || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure hold%0d: res=%h valid=%b ready=%b, required res=%h 1/0",
                     i, got, bus.out_valid, bus.in_ready, ex);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure release: ready=%b valid=%b, required 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      res_t ex1, ex2, got;
      logic rdy_seen;
      int   lat;
      ex1 = model(32'h40400000, 32'h3E800000, 3'd1);
      ex2 = model(32'h00400000, 32'h41200000, 3'd6);
      drive_op(32'h40400000, 32'h3E800000, 3'd1, rdy_seen, lat, got);
      vectors++;
      if (got !== ex1) begin
         miscompares++;
         $display("FAIL back_to_back first: %h, required %h", got, ex1);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_A      = 32'h00400000;
      bus.in_B      = 32'h41200000;
      bus.in_rm     = 3'd6;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back gap: ready=%b valid=%b, required 1/0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      got = sample();
      vectors++;
      if (lat !== LAT || got !== ex2) begin
         miscompares++;
         $display("FAIL back_to_back second: lat=%0d res=%h, required lat=%0d res=%h", lat, got, LAT, ex2);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      res_t ex, got;
      logic rdy_seen;
      int   lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_A     = 32'hBFC00000;
      bus.in_B     = 32'h40400000;
      bus.in_rm    = 3'd7;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      got = sample();
      vectors++;
      if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_op: res=%h valid=%b ready=%b, required 0/0/1", got, bus.out_valid, bus.in_ready);
      end
      ex = '0;
      ex.exp_db = 9'd254;
      ex.man    = 48'h900000000000;
      ex.rm     = 3'd2;
      ex.a_pos  = 1'b1;
      ex.b_pos  = 1'b1;
      drive_op(32'h3FC00000, 32'h3FC00000, 3'd2, rdy_seen, lat, got);
      vectors++;
      if (lat !== LAT || got !== ex) begin
         miscompares++;
         $display("FAIL reset_mid_op rerun: lat=%0d res=%h, required lat=%0d res=%h", lat, got, LAT, ex);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_A      = '0;
      bus.in_B      = '0;
      bus.in_rm     = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
